// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_pkg;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 32;
    localparam int IDX_W      = 5;
    localparam int NUM_WB_REQ = 2;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
    } wb_req_t;

    typedef logic [DEPTH-1:0] busy_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority pointer moves only when
// a contended grant is accepted.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // r_ptr=1 gives requester 1 priority on the next contention.
    logic r_ptr;

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept && (i_valid == 2'b11)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: round-robin write port arbitration,
// registered write port and busy scoreboard. Optional macro REGFILE_BYPASS_EN
// forwards the in-flight write to the hazard checks.
module regfile_wb_ctrl #(
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int DEPTH = regfile_pkg::DEPTH,
    parameter int IDX_W = regfile_pkg::IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    input  logic [IDX_W-1:0] i_issue_idx,
    input  logic             i_req0_valid,
    input  logic [IDX_W-1:0] i_req0_idx,
    input  logic [WIDTH-1:0] i_req0_data,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [IDX_W-1:0] i_req1_idx,
    input  logic [WIDTH-1:0] i_req1_data,
    output logic             o_req1_ready,
    output logic             o_rf_wr,
    output logic [IDX_W-1:0] o_rf_c_idx,
    output logic [WIDTH-1:0] o_rf_c,
    input  logic [IDX_W-1:0] i_chk_a_idx,
    input  logic [IDX_W-1:0] i_chk_b_idx,
    output logic             o_hazard_a,
    output logic             o_hazard_b,
    output logic [DEPTH-1:0] o_busy,
    output logic             o_fwd_a_valid,
    output logic [WIDTH-1:0] o_fwd_a,
    output logic             o_fwd_b_valid,
    output logic [WIDTH-1:0] o_fwd_b
);

    import regfile_pkg::*;

    logic [NUM_WB_REQ-1:0] w_valid;
    logic [NUM_WB_REQ-1:0] w_grant;
    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_acc;
    wb_req_t               w_sel;
    logic                  w_sel_wr;
    busy_t                 w_busy_nxt;

    logic                  r_wr;
    logic [IDX_W-1:0]      r_idx;
    logic [WIDTH-1:0]      r_data;
    busy_t                 r_busy;

    assign w_valid = {i_req1_valid, i_req0_valid};

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_valid),
        .i_accept(w_acc),
        .o_grant (w_grant)
    );

    // Handshake: a requester holds valid with stable idx/data until it sees ready;
    // the write-back is taken at the edge where valid & ready are both high.
    assign o_req0_ready = i_req0_valid & w_grant[0] & ~i_rst;
    assign o_req1_ready = i_req1_valid & w_grant[1] & ~i_rst;
    assign w_acc0       = o_req0_ready;
    assign w_acc1       = o_req1_ready;
    assign w_acc        = w_acc0 | w_acc1;

    always_comb begin
        w_sel.idx  = i_req0_idx;
        w_sel.data = i_req0_data;
        if (w_acc1) begin
            w_sel.idx  = i_req1_idx;
            w_sel.data = i_req1_data;
        end
    end

    // Register 0 is hardwired, so its write-backs are consumed without a write.
    assign w_sel_wr = w_acc && (w_sel.idx != '0);

    // A new producer issued at the commit edge must keep the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr) begin
            w_busy_nxt[r_idx] = 1'b0;
        end
        if (i_issue_valid) begin
            w_busy_nxt[i_issue_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr   <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
            r_busy <= '0;
        end else begin
            r_wr   <= w_sel_wr;
            r_busy <= w_busy_nxt;
            if (w_sel_wr) begin
                r_idx  <= w_sel.idx;
                r_data <= w_sel.data;
            end
        end
    end

    assign o_rf_wr    = r_wr;
    assign o_rf_c_idx = r_idx;
    assign o_rf_c     = r_data;
    assign o_busy     = r_busy;

`ifdef REGFILE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a       = r_wr && (r_idx == i_chk_a_idx) && (i_chk_a_idx != '0);
    assign w_byp_b       = r_wr && (r_idx == i_chk_b_idx) && (i_chk_b_idx != '0);
    assign o_fwd_a_valid = w_byp_a;
    assign o_fwd_b_valid = w_byp_b;
    assign o_fwd_a       = w_byp_a ? r_data : '0;
    assign o_fwd_b       = w_byp_b ? r_data : '0;
    assign o_hazard_a    = r_busy[i_chk_a_idx] & ~w_byp_a;
    assign o_hazard_b    = r_busy[i_chk_b_idx] & ~w_byp_b;
`else
    assign o_fwd_a_valid = 1'b0;
    assign o_fwd_b_valid = 1'b0;
    assign o_fwd_a       = '0;
    assign o_fwd_b       = '0;
    assign o_hazard_a    = r_busy[i_chk_a_idx];
    assign o_hazard_b    = r_busy[i_chk_b_idx];
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl; write-port traffic is checked against an
// expected queue, other outputs are checked inline.
module tb_regfile_wb_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic             req0_valid;
    logic [IDX_W-1:0] req0_idx;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [IDX_W-1:0] req1_idx;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             rf_wr;
    logic [IDX_W-1:0] rf_c_idx;
    logic [WIDTH-1:0] rf_c;
    logic [IDX_W-1:0] chk_a_idx;
    logic [IDX_W-1:0] chk_b_idx;
    logic             hazard_a;
    logic             hazard_b;
    logic [DEPTH-1:0] busy;
    logic             fwd_a_valid;
    logic [WIDTH-1:0] fwd_a;
    logic             fwd_b_valid;
    logic [WIDTH-1:0] fwd_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [IDX_W+WIDTH-1:0] exp_q[$];
    logic [IDX_W+WIDTH-1:0] mon_e;

    regfile_wb_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_issue_valid(issue_valid),
        .i_issue_idx  (issue_idx),
        .i_req0_valid (req0_valid),
        .i_req0_idx   (req0_idx),
        .i_req0_data  (req0_data),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_idx   (req1_idx),
        .i_req1_data  (req1_data),
        .o_req1_ready (req1_ready),
        .o_rf_wr      (rf_wr),
        .o_rf_c_idx   (rf_c_idx),
        .o_rf_c       (rf_c),
        .i_chk_a_idx  (chk_a_idx),
        .i_chk_b_idx  (chk_b_idx),
        .o_hazard_a   (hazard_a),
        .o_hazard_b   (hazard_b),
        .o_busy       (busy),
        .o_fwd_a_valid(fwd_a_valid),
        .o_fwd_a      (fwd_a),
        .o_fwd_b_valid(fwd_b_valid),
        .o_fwd_b      (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] data);
        exp_q.push_back({idx, data});
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 64'(rf_c_idx), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_idx", 64'(rf_c_idx), 64'(mon_e[IDX_W+WIDTH-1:WIDTH]));
                chk("wr_data", 64'(rf_c), 64'(mon_e[WIDTH-1:0]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_idx = '0;
        req0_valid = 1'b1; req0_idx = 5'd5; req0_data = 32'hDEAD;
        req1_valid = 1'b0; req1_idx = '0; req1_data = '0;
        chk_a_idx = '0; chk_b_idx = '0;

        // Reset held for two edges with req0 pending.
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready0", 64'(req0_ready), 64'd0);
            chk("rst_rf_wr", 64'(rf_wr), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rf_c_idx", 64'(rf_c_idx), 64'd0);
            chk("rst_rf_c", 64'(rf_c), 64'd0);
        end
        rst = 1'b0;
        expect_wr(5'd5, 32'hDEAD);
        #1;
        chk("post_rst_ready0", 64'(req0_ready), 64'd1);
        chk("post_rst_ready1", 64'(req1_ready), 64'd0);

        // Contention: grants alternate starting with req0.
        @(negedge clk);
        req0_valid = 1'b1; req0_idx = 5'd1; req0_data = 32'h1111;
        req1_valid = 1'b1; req1_idx = 5'd2; req1_data = 32'h2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", 64'(req0_ready), 64'((k % 2) == 0));
            chk("rr_ready1", 64'(req1_ready), 64'((k % 2) == 1));
            if ((k % 2) == 0) expect_wr(5'd1, 32'h1111);
            else              expect_wr(5'd2, 32'h2222);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Scoreboard set/clear on idx 7.
        issue_valid = 1'b1; issue_idx = 5'd7; chk_a_idx = 5'd7;
        #1;
        chk("haz7_before", 64'(hazard_a), 64'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        chk("haz7_set", 64'(hazard_a), 64'd1);
        chk("busy7_set", 64'(busy), 64'h80);
        req1_valid = 1'b1; req1_idx = 5'd7; req1_data = 32'h7777;
        #1;
        chk("wb7_ready1", 64'(req1_ready), 64'd1);
        chk("wb7_ready0", 64'(req0_ready), 64'd0);
        expect_wr(5'd7, 32'h7777);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("busy7_wr_cycle", 64'(busy), 64'h80);
`ifdef REGFILE_BYPASS_EN
        chk("haz7_wr_cycle", 64'(hazard_a), 64'd0);
        chk("fwd7_valid", 64'(fwd_a_valid), 64'd1);
        chk("fwd7_data", 64'(fwd_a), 64'h7777);
`else
        chk("haz7_wr_cycle", 64'(hazard_a), 64'd1);
        chk("fwd7_valid", 64'(fwd_a_valid), 64'd0);
        chk("fwd7_data", 64'(fwd_a), 64'd0);
`endif
        @(negedge clk);
        chk("busy7_clear", 64'(busy), 64'd0);
        chk("haz7_clear", 64'(hazard_a), 64'd0);
        chk("fwd7_after", 64'(fwd_a_valid), 64'd0);

        // Pointer untouched by the lone req1 grant: req0 wins next contention.
        req0_valid = 1'b1; req0_idx = 5'd10; req0_data = 32'hA0A0;
        req1_valid = 1'b1; req1_idx = 5'd11; req1_data = 32'hB1B1;
        #1;
        chk("ptr_ready0", 64'(req0_ready), 64'd1);
        chk("ptr_ready1", 64'(req1_ready), 64'd0);
        expect_wr(5'd10, 32'hA0A0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("ptr_req1_alone", 64'(req1_ready), 64'd1);
        expect_wr(5'd11, 32'hB1B1);
        @(negedge clk);
        req1_valid = 1'b0;

        // Issue and commit of idx 9 at the same edge: set wins.
        issue_valid = 1'b1; issue_idx = 5'd9;
        req0_valid = 1'b1; req0_idx = 5'd9; req0_data = 32'h9999;
        expect_wr(5'd9, 32'h9999);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("busy9_set", 64'(busy), 64'h200);
        @(negedge clk);
        issue_valid = 1'b0;
        chk("busy9_same_edge", 64'(busy), 64'h200);
        @(negedge clk);
        chk("busy9_held", 64'(busy), 64'h200);

        // Index 0: handshaked but never written, never busy, never a hazard.
        req0_valid = 1'b1; req0_idx = 5'd0; req0_data = 32'h1234;
        issue_valid = 1'b1; issue_idx = 5'd0; chk_a_idx = 5'd0;
        #1;
        chk("idx0_ready0", 64'(req0_ready), 64'd1);
        chk("idx0_hazard", 64'(hazard_a), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; issue_valid = 1'b0;
        chk("idx0_rf_wr", 64'(rf_wr), 64'd0);
        chk("idx0_busy", 64'(busy), 64'h200);
        chk("idx0_hold_idx", 64'(rf_c_idx), 64'd9);
        chk("idx0_hold_data", 64'(rf_c), 64'h9999);

        // Forwarding on read port B for idx 3.
        issue_valid = 1'b1; issue_idx = 5'd3; chk_b_idx = 5'd3;
        req1_valid = 1'b1; req1_idx = 5'd3; req1_data = 32'hCAFE;
        #1;
        chk("haz3_before", 64'(hazard_b), 64'd0);
        expect_wr(5'd3, 32'hCAFE);
        @(negedge clk);
        issue_valid = 1'b0; req1_valid = 1'b0;
        chk("busy3_set", 64'(busy), 64'h208);
`ifdef REGFILE_BYPASS_EN
        chk("byp3_valid", 64'(fwd_b_valid), 64'd1);
        chk("byp3_data", 64'(fwd_b), 64'hCAFE);
        chk("byp3_hazard", 64'(hazard_b), 64'd0);
`else
        chk("byp3_valid", 64'(fwd_b_valid), 64'd0);
        chk("byp3_data", 64'(fwd_b), 64'd0);
        chk("byp3_hazard", 64'(hazard_b), 64'd1);
`endif
        @(negedge clk);
        chk("busy3_clear", 64'(busy), 64'h200);
        chk("haz3_clear", 64'(hazard_b), 64'd0);
        chk("fwd3_after", 64'(fwd_b_valid), 64'd0);

        repeat (2) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
